// File: rtl/frost32_irq_ctrl.sv
// Interrupt controller feeding the Frost32 CPU interrupt input: edge-captured
// pending sources, lowest-index priority, stall-aware hold, EOI tracking and a
// post-EOI gap. Define IRQ_CTRL_DROP_CNT_EN to add the drop_cnt output.
module frost32_irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int MIN_GAP     = 2,
    parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               wait_for_mem,
    input  logic               eoi,
    input  logic [ID_W-1:0]    eoi_id,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic               irq_busy,
    output logic [NUM_SRC-1:0] pending,
`ifdef IRQ_CTRL_DROP_CNT_EN
    output logic [15:0]        drop_cnt,
`endif
    output logic               eoi_err
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GC_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_IN_SERVICE,
        ST_GAP
    } state_t;

    state_t             state_reg;
    logic [HC_W-1:0]    hold_cnt_reg;
    logic [GC_W-1:0]    gap_cnt_reg;
    logic               interrupt_reg;
    logic               busy_reg;
    logic [ID_W-1:0]    irq_id_reg;
    logic               eoi_err_reg;
    logic [NUM_SRC-1:0] prev_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_oh;
    logic [ID_W-1:0]    win_id;
    logic               accept;

    assign rise     = irq_src & ~prev_reg;
    assign eligible = pending_reg & irq_mask;
    assign accept   = (state_reg == ST_IDLE) && (|eligible) && !wait_for_mem;

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
            assign clr_oh[gi] = accept && (win_id == ID_W'(gi));
        end
    endgenerate

    // A new edge on the source being accepted keeps it pending.
    assign pending_next = (pending_reg & ~clr_oh) | rise;

    // History starts all ones so lines already high at reset release are not edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg    <= '1;
            pending_reg <= '0;
        end else begin
            prev_reg    <= irq_src;
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            interrupt_reg <= 1'b0;
            busy_reg      <= 1'b0;
            irq_id_reg    <= '0;
            eoi_err_reg   <= 1'b0;
        end else begin
            eoi_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (eoi) begin
                        eoi_err_reg <= 1'b1;
                    end
                    if (accept) begin
                        irq_id_reg    <= win_id;
                        hold_cnt_reg  <= '0;
                        interrupt_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (eoi) begin
                        eoi_err_reg <= 1'b1;
                    end
                    // Stalled cycles do not count: the CPU cannot sample interrupt then.
                    if (!wait_for_mem) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            interrupt_reg <= 1'b0;
                            state_reg     <= ST_IN_SERVICE;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_IN_SERVICE: begin
                    if (eoi) begin
                        if (eoi_id == irq_id_reg) begin
                            busy_reg    <= 1'b0;
                            gap_cnt_reg <= '0;
                            if (MIN_GAP == 0) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                state_reg <= ST_GAP;
                            end
                        end else begin
                            eoi_err_reg <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (eoi) begin
                        eoi_err_reg <= 1'b1;
                    end
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    interrupt_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;
    logic        drop_any;

    assign drop_any = |(rise & pending_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (drop_any && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    assign interrupt = interrupt_reg;
    assign irq_id    = irq_id_reg;
    assign irq_busy  = busy_reg;
    assign pending   = pending_reg;
    assign eoi_err   = eoi_err_reg;

endmodule

// File: tb/tb_frost32_irq_ctrl.sv
// Directed bench for frost32_irq_ctrl with default parameters (8 sources,
// hold 4, gap 2); drop_cnt checks are compiled in with IRQ_CTRL_DROP_CNT_EN.
module tb_frost32_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_src;
    logic [7:0] irq_mask;
    logic       wait_for_mem;
    logic       eoi;
    logic [2:0] eoi_id;
    logic       interrupt;
    logic [2:0] irq_id;
    logic       irq_busy;
    logic [7:0] pending;
    logic       eoi_err;
`ifdef IRQ_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    frost32_irq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .irq_mask     (irq_mask),
        .wait_for_mem (wait_for_mem),
        .eoi          (eoi),
        .eoi_id       (eoi_id),
        .interrupt    (interrupt),
        .irq_id       (irq_id),
        .irq_busy     (irq_busy),
        .pending      (pending),
`ifdef IRQ_CTRL_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .eoi_err      (eoi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_eoi(input logic [2:0] id);
        eoi    = 1'b1;
        eoi_id = id;
        step();
        eoi    = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq_src = lines;
        step();
        irq_src = 8'h00;
    endtask

    initial begin
        rst_n        = 1'b0;
        irq_src      = 8'h01;
        irq_mask     = 8'hFF;
        wait_for_mem = 1'b0;
        eoi          = 1'b0;
        eoi_id       = 3'd0;
        repeat (2) step();
        chk("rst_pending",   pending,   8'h00);
        chk("rst_interrupt", interrupt, 1'b0);
        chk("rst_irq_id",    irq_id,    3'd0);
        chk("rst_busy",      irq_busy,  1'b0);
        chk("rst_eoi_err",   eoi_err,   1'b0);
`ifdef IRQ_CTRL_DROP_CNT_EN
        chk("rst_drop_cnt",  drop_cnt,  16'd0);
`endif

        // Test 1: line already high at reset release is not an edge.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_pending",   pending,   8'h00);
            chk("t1_interrupt", interrupt, 1'b0);
        end
        irq_src = 8'h00;
        step();

        // Test 2: single source 3, four-cycle hold, EOI, two-cycle gap.
        pulse(8'h08);
        chk("t2_pend_set", pending,   8'h08);
        chk("t2_int_pre",  interrupt, 1'b0);
        step();
        chk("t2_int_on",   interrupt, 1'b1);
        chk("t2_id",       irq_id,    3'd3);
        chk("t2_pend_clr", pending,   8'h00);
        chk("t2_busy",     irq_busy,  1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_int_hold", interrupt, 1'b1);
        end
        step();
        chk("t2_int_off",  interrupt, 1'b0);
        chk("t2_busy_svc", irq_busy,  1'b1);
        do_eoi(3'd3);
        chk("t2_gap_busy", irq_busy, 1'b0);
        chk("t2_gap_err",  eoi_err,  1'b0);
        repeat (2) step();

        // Test 3: simultaneous 5 and 2, lowest index first, gap before source 5.
        pulse(8'h24);
        chk("t3_pend_both", pending, 8'h24);
        step();
        chk("t3_int_on", interrupt, 1'b1);
        chk("t3_id2",    irq_id,    3'd2);
        chk("t3_pend5",  pending,   8'h20);
        repeat (3) step();
        step();
        chk("t3_int_off", interrupt, 1'b0);
        do_eoi(3'd2);
        chk("t3_gap0_int",  interrupt, 1'b0);
        chk("t3_gap0_busy", irq_busy,  1'b0);
        step();
        chk("t3_gap1_int", interrupt, 1'b0);
        step();
        chk("t3_idle_int",  interrupt, 1'b0);
        chk("t3_idle_pend", pending,   8'h20);
        step();
        chk("t3_int5_on", interrupt, 1'b1);
        chk("t3_id5",     irq_id,    3'd5);
        chk("t3_pend0",   pending,   8'h00);
        repeat (3) step();
        step();
        chk("t3_int5_off", interrupt, 1'b0);
        do_eoi(3'd5);
        repeat (2) step();

        // Test 4a: stall of three cycles stretches the pulse to seven cycles.
        pulse(8'h02);
        step();
        chk("t4_int_on", interrupt, 1'b1);
        chk("t4_id1",    irq_id,    3'd1);
        wait_for_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_int_stall", interrupt, 1'b1);
        end
        wait_for_mem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_int_run", interrupt, 1'b1);
        end
        step();
        chk("t4_int_off", interrupt, 1'b0);
        do_eoi(3'd1);
        repeat (2) step();

        // Test 4b: stall in IDLE holds off delivery.
        wait_for_mem = 1'b1;
        pulse(8'h40);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_idle_int",  interrupt, 1'b0);
            chk("t4_idle_pend", pending,   8'h40);
        end
        wait_for_mem = 1'b0;
        step();
        chk("t4_int6_on", interrupt, 1'b1);
        chk("t4_id6",     irq_id,    3'd6);
        repeat (3) step();
        step();
        do_eoi(3'd6);
        repeat (2) step();

        // Test 5: EOI errors in ASSERT, with wrong id, and in IDLE.
        pulse(8'h10);
        step();
        chk("t5_id4", irq_id, 3'd4);
        do_eoi(3'd4);
        chk("t5_err_assert", eoi_err,   1'b1);
        chk("t5_int_kept",   interrupt, 1'b1);
        step();
        chk("t5_err_clr",  eoi_err,   1'b0);
        step();
        chk("t5_int_last", interrupt, 1'b1);
        step();
        chk("t5_int_off",  interrupt, 1'b0);
        do_eoi(3'd1);
        chk("t5_err_wrong", eoi_err,  1'b1);
        chk("t5_busy_stay", irq_busy, 1'b1);
        chk("t5_id_stay",   irq_id,   3'd4);
        step();
        chk("t5_err_once", eoi_err,  1'b0);
        chk("t5_busy_svc", irq_busy, 1'b1);
        do_eoi(3'd4);
        chk("t5_busy_gap", irq_busy, 1'b0);
        chk("t5_err_ok",   eoi_err,  1'b0);
        repeat (2) step();
        do_eoi(3'd0);
        chk("t5_err_idle", eoi_err, 1'b1);
        step();
        chk("t5_err_idle_once", eoi_err, 1'b0);

        // Test 6: masked source collects drops, then async reset mid-ASSERT.
        irq_mask = 8'h00;
`ifdef IRQ_CTRL_DROP_CNT_EN
        chk("t6_drop_start", drop_cnt, 16'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            pulse(8'h01);
            step();
        end
        chk("t6_pend0",      pending,   8'h01);
        chk("t6_int_masked", interrupt, 1'b0);
`ifdef IRQ_CTRL_DROP_CNT_EN
        chk("t6_drop_cnt", drop_cnt, 16'd2);
`endif
        irq_mask = 8'hFF;
        step();
        chk("t6_int_on", interrupt, 1'b1);
        chk("t6_id0",    irq_id,    3'd0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_int",  interrupt, 1'b0);
        chk("t6_rst_busy", irq_busy,  1'b0);
        chk("t6_rst_pend", pending,   8'h00);
`ifdef IRQ_CTRL_DROP_CNT_EN
        chk("t6_rst_drop", drop_cnt, 16'd0);
`endif
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t6_post_int", interrupt, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
